// File: rtl/factor_pkg.sv
// Shared types and constants for the sequential factor search/check engine.
package factor_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MUL  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic MODE_CHECK  = 1'b0;
  localparam logic MODE_SEARCH = 1'b1;

  // Number of candidate pairs (a, b) with 2 <= a <= b <= 2^w-1.
  function automatic longint pair_count(input int w);
    longint top;
    top = (longint'(1) << w) - 1;
    return ((top - 1) * top) / 2;
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// W-cycle shift-add multiplier; a and b must stay stable while it runs.
module shift_add_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] acc,
  output logic           mul_done
);

  localparam int IW = $clog2(W);

  logic [IW-1:0]  idx;
  logic           active;
  logic           last;
  logic [W-1:0]   b_shr;
  logic [2*W-1:0] addend;

  assign last     = (idx == IW'(W - 1));
  assign b_shr    = b >> idx;
  assign addend   = b_shr[0] ? ({{W{1'b0}}, a} << idx) : '0;
  // Asserted during the final accumulation step, so acc is final on the next cycle.
  assign mul_done = active && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      idx    <= '0;
      active <= 1'b0;
    end else if (load) begin
      acc    <= '0;
      idx    <= '0;
      active <= 1'b1;
    end else if (active) begin
      acc <= acc + addend;
      if (last) begin
        idx    <= '0;
        active <= 1'b0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/factor_search_seq.sv
// Sequential factorization oracle: CHECK verifies a supplied pair, SEARCH
// enumerates pairs a <= b from (2,2) and reports the first non-trivial match.
module factor_search_seq
  import factor_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = 2 * W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           mode,
  input  logic           abort,
  input  logic [2*W-1:0] target,
  input  logic [W-1:0]   f1_in,
  input  logic [W-1:0]   f2_in,
  output logic           busy,
  output logic           done,
  output logic           found,
  output logic [W-1:0]   f1_out,
  output logic [W-1:0]   f2_out,
  output logic [CW-1:0]  tried_cnt
);

  localparam logic [W-1:0] MAXV = {W{1'b1}};
  localparam logic [W-1:0] TWO  = W'(2);

  // Handshake: start is sampled only while busy is low; busy then stays high
  // until the cycle after the one-cycle done pulse. abort drops busy without done.

  state_t         state;
  logic           mode_q;
  logic [2*W-1:0] target_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc;
  logic           mul_done;
  logic           match;
  logic           adv;
  logic           load;

  assign match = (acc == target_q) && (a_q >= TWO) && (b_q >= TWO);
  assign adv   = (mode_q == MODE_SEARCH) && !match && !((a_q == MAXV) && (b_q == MAXV));
  assign load  = (state == LOAD) || ((state == CMP) && adv);

  shift_add_mul #(.W(W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .a        (a_q),
    .b        (b_q),
    .acc      (acc),
    .mul_done (mul_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_CHECK;
      target_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      f1_out    <= '0;
      f2_out    <= '0;
      tried_cnt <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            mode_q    <= mode;
            target_q  <= target;
            a_q       <= (mode == MODE_SEARCH) ? TWO : f1_in;
            b_q       <= (mode == MODE_SEARCH) ? TWO : f2_in;
            found     <= 1'b0;
            f1_out    <= '0;
            f2_out    <= '0;
            tried_cnt <= '0;
          end
        end
        LOAD: state <= MUL;
        MUL: begin
          if (mul_done) state <= CMP;
        end
        CMP: begin
          tried_cnt <= tried_cnt + CW'(1);
          if ((mode_q == MODE_CHECK) || match) begin
            state  <= DONE;
            done   <= 1'b1;
            found  <= match;
            f1_out <= a_q;
            f2_out <= b_q;
          end else if (adv) begin
            state <= MUL;
            if (b_q != MAXV) begin
              b_q <= b_q + W'(1);
            end else begin
              a_q <= a_q + W'(1);
              b_q <= a_q + W'(1);
            end
          end else begin
            // Every pair tried: report not-found with zeroed factors.
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
